// File: rtl/blit_pkg.sv
// Shared types and phase-ordering helper for the blitter inner-loop sequencer.
// SREADX is only reachable when BLIT_SRCX_EN is defined (see blit_mseq).
package blit_pkg;

    localparam int ICNT_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SREADX = 3'd1,
        ST_SREAD  = 3'd2,
        ST_DREAD  = 3'd3,
        ST_DWRITE = 3'd4
    } blit_state_e;

    // Next enabled memory phase after cur; DWRITE is always enabled and
    // DWRITE -> IDLE is decided by the caller (last pixel / abort).
    function automatic blit_state_e next_phase(input blit_state_e cur,
                                               input logic srcx_en,
                                               input logic src_en,
                                               input logic dst_en);
        blit_state_e nxt;
        nxt = ST_DWRITE;
        case (cur)
            ST_IDLE: begin
                if (srcx_en)     nxt = ST_SREADX;
                else if (src_en) nxt = ST_SREAD;
                else if (dst_en) nxt = ST_DREAD;
            end
            ST_SREADX, ST_DWRITE: begin
                if (src_en)      nxt = ST_SREAD;
                else if (dst_en) nxt = ST_DREAD;
            end
            ST_SREAD: begin
                if (dst_en)      nxt = ST_DREAD;
            end
            default: nxt = ST_DWRITE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/blit_icount.sv
// Loadable down-counter for the inner-loop pixel count, with last (==1)
// and zero flags. Decrement never wraps below zero.
module blit_icount
    import blit_pkg::*;
#(
    parameter int W = ICNT_W_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         last,
    output logic         zero
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == W'(1));
    assign zero = (count == '0);

endmodule

// File: rtl/blit_mseq.sv
// Blitter memory-cycle sequencer: issues SREADX/SREAD/DREAD/DWRITE requests
// per pixel, advancing on memready. Optional macro: BLIT_SRCX_EN (SREADX phase).
module blit_mseq
    import blit_pkg::*;
#(
    parameter int ICNT_W = ICNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              srcen,
    input  logic              srcenx,
    input  logic              dsten,
    input  logic [ICNT_W-1:0] inner_count,
    input  logic              memready,
    output logic              readreq,
    output logic              writereq,
    output logic              sread_1,
    output logic              sreadx_1,
    output logic              dread,
    output logic              dwrite,
    output logic              step_inner,
    output logic              busy,
    output logic              done,
    output logic [ICNT_W-1:0] icnt
);

    blit_state_e state, state_nxt;
    logic        srcx_q, src_q, dst_q;
    logic        abort_pend;
    logic        srcx_in;
    logic        accept, pending, dw_done;
    logic        cnt_last, cnt_zero;

`ifdef BLIT_SRCX_EN
    assign srcx_in = srcenx;
`else
    logic unused_srcenx;
    assign srcx_in       = 1'b0;
    assign unused_srcenx = srcenx;
`endif

    assign accept  = (state == ST_IDLE) && start;
    assign pending = abort_pend || abort;
    assign dw_done = (state == ST_DWRITE) && memready;

    blit_icount #(.W(ICNT_W)) u_icount (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (accept),
        .load_val (inner_count),
        .dec      (dw_done),
        .count    (icnt),
        .last     (cnt_last),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start && inner_count != '0)
                    state_nxt = next_phase(ST_IDLE, srcx_in, srcen, dsten);
            end
            ST_DWRITE: begin
                if (memready)
                    state_nxt = (pending || cnt_last || cnt_zero) ? ST_IDLE
                              : next_phase(ST_DWRITE, srcx_q, src_q, dst_q);
            end
            default: begin
                if (memready)
                    state_nxt = pending ? ST_IDLE
                              : next_phase(state, srcx_q, src_q, dst_q);
            end
        endcase
    end

    // Outputs are registered from state_nxt so they equal a decode of state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            srcx_q     <= 1'b0;
            src_q      <= 1'b0;
            dst_q      <= 1'b0;
            abort_pend <= 1'b0;
            readreq    <= 1'b0;
            writereq   <= 1'b0;
            sread_1    <= 1'b0;
            sreadx_1   <= 1'b0;
            dread      <= 1'b0;
            dwrite     <= 1'b0;
            step_inner <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                srcx_q <= srcx_in;
                src_q  <= srcen;
                dst_q  <= dsten;
            end
            abort_pend <= (state == ST_IDLE) ? (start && abort) : (abort_pend || abort);
            readreq    <= (state_nxt inside {ST_SREADX, ST_SREAD, ST_DREAD});
            writereq   <= (state_nxt == ST_DWRITE);
`ifdef BLIT_SRCX_EN
            sreadx_1   <= (state_nxt == ST_SREADX);
`else
            sreadx_1   <= 1'b0;
`endif
            sread_1    <= (state_nxt == ST_SREAD);
            dread      <= (state_nxt == ST_DREAD);
            dwrite     <= (state_nxt == ST_DWRITE);
            busy       <= (state_nxt != ST_IDLE);
            step_inner <= dw_done;
            done       <= (accept && inner_count == '0)
                       || (state != ST_IDLE && memready && state_nxt == ST_IDLE);
        end
    end

endmodule

// File: doc/blit_mseq.md
# blit_mseq

Blitter memory-cycle sequencer for the inner loop. It issues per-pixel source-read, destination-read and destination-write requests to the blitter memory controller, and advances on that controller's `memready` handshake. It counts inner-loop iterations and pulses `step_inner` so the controller latches the next address. It sits between the blitter state/address logic and the memory controller.

## Interface
Parameters:
- `ICNT_W`, default 16: inner-count width.

Ports (one clock, `clk`; reset is asynchronous and active-low, `reset_n`):
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle pulse that begins an inner loop. Honoured only in IDLE.
- `abort` in 1: finish the current memory cycle, then return to IDLE.
- `srcen` in 1: perform a source read per pixel.
- `srcenx` in 1: perform one extra source read before the first pixel.
- `dsten` in 1: perform a destination read per pixel.
- `inner_count` in ICNT_W: pixel count, index 0 is the LSB. Sampled on an accepted `start`.
- `memready` in 1: current request completed; equals `blitack & active` from the memory controller.
- `readreq` out 1: read request to the memory controller.
- `writereq` out 1: write request to the memory controller.
- `sread_1`, `sreadx_1`, `dread`, `dwrite` out 1 each: one-hot phase indicators.
- `step_inner` out 1: one-cycle pulse that latches the next address.
- `busy` out 1: high when state is not IDLE.
- `done` out 1: one-cycle pulse at the end of the loop.
- `icnt` out ICNT_W: pixels remaining.

## Operation
- States: IDLE, SREADX, SREAD, DREAD, DWRITE.
- Outputs are Moore outputs of the state:
  - `readreq` = SREADX | SREAD | DREAD.
  - `writereq` = DWRITE.
  - Each phase flag is high only in its own state.
- Start, IDLE with `start`=1:
  - Load `icnt` ← `inner_count`.
  - If `inner_count`=0, pulse `done` next cycle and stay in IDLE.
  - Otherwise go to the first enabled state in the order SREADX (if `srcenx`) → SREAD (if `srcen`) → DREAD (if `dsten`) → DWRITE.
- Memory states:
  - Hold the state and request until `memready`=1.
  - On `memready`, move to the next enabled state in the order above. DWRITE is always enabled.
  - SREADX is entered only for the first pixel of a loop.
- DWRITE completion (`memready` in DWRITE):
  - Decrement `icnt`.
  - Pulse `step_inner`.
  - If `icnt` was 1, or `abort` is pending, go to IDLE and pulse `done`.
  - Otherwise go to the first enabled of SREAD, DREAD, DWRITE.
- Abort:
  - `abort` sets a sticky `abort_pend` flag, cleared in IDLE.
  - On the next `memready`, go to IDLE and pulse `done`.
  - A DWRITE completion that coincides with this still decrements `icnt` and pulses `step_inner`.
  - `abort` in IDLE has no effect.
- Enable sampling: `srcen`, `srcenx` and `dsten` are sampled at `start` into registers. Changing them mid-loop has no effect.
- Reset: every output is 0, state is IDLE, `icnt` is 0, `abort_pend` is 0.
- Reset asserted mid-cycle drops the requests immediately. The memory controller's own reset clears its `ractive`/`wactive`.

## Timing
- Latency from `start` to the first request: 1 cycle (request high from the next edge).
- Back-to-back reads: `readreq` stays high across the state change, so the memory controller keeps `ractive` with no idle cycle.
- The transition out of a state occurs on the edge where `memready`=1 is sampled. The next request is visible in the following cycle.
- `step_inner` and `done` are registered and asserted for exactly one cycle, in the cycle after the final `memready`.
- `start` while `busy`=1 is ignored. `start` and `abort` in the same IDLE cycle: `start` wins and `abort_pend` is set, so the loop ends after its first memory cycle.
- Per pixel the minimum is (enabled phases) cycles plus memory wait. With a single DWRITE phase and `memready` constantly high: 1 pixel per cycle.

## Configuration
- `BLIT_SRCX_EN` defined: SREADX exists, `srcenx` is honoured, `sreadx_1` is driven.
- Without it: SREADX is removed, `srcenx` is ignored, `sreadx_1` is tied to 0.

## Structure
- The shared package `blit_pkg` holds:
  - the state enum (IDLE, SREADX, SREAD, DREAD, DWRITE);
  - `ICNT_W_DEF`=16;
  - a next-phase function taking the current state and the registered enables.
- Sub-module `blit_icount`: loadable down-counter with a `last` (==1) flag and a zero-detect, instantiated once.

## Test plan
- `srcen`=1, `dsten`=1, `inner_count`=3, `memready` high each cycle after a request:
  - request sequence R,R,W ×3;
  - `step_inner` pulses 3 times;
  - `done` 1 cycle after the 3rd W;
  - `icnt` ends at 0.
- `inner_count`=0 with `start`: no `readreq`/`writereq` ever; `done` pulses on the next cycle; `busy` stays 0.
- With `BLIT_SRCX_EN`, `srcenx`=1, `srcen`=1, `inner_count`=2: sequence SREADX, SREAD, DWRITE, SREAD, DWRITE. Without the macro: SREADX is absent.
- `memready` held low 5 cycles in DREAD: `readreq` and `dread` hold steady; no state change; `icnt` unchanged.
- `abort` pulsed during the SREAD of pixel 2 of 4: after `memready`, IDLE; `done` pulses; `icnt`=3; no further requests.
- `reset_n` low during DWRITE: all outputs 0 asynchronously; after release, `start` with count 1 runs normally.
